uart_transmitter: RTL and testbench

//   Serialises one character per request onto the UART tx line. Counterpart of the

---
 rtl/uart_transmitter.sv | 159 +++++++++++++++
 tb/tb_uart_transmitter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one character per accepted request (5-8 data bits,
// optional parity, 1 or 2 stop bits, programmable bit period) and drives line breaks.
module uart_transmitter #(
  parameter int CLOCK_DIVISOR_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [7:0]                     dataIn,
  input  logic                           sendData,
  output logic                           ready,
  input  logic                           sendBreak,
  output logic                           tx,
  output logic                           busy,
  output logic                           dataSent
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_MARK   = 3'd6;

  logic [2:0]                     r_state;
  logic [CLOCK_DIVISOR_WIDTH-1:0] r_div_cnt;
  logic [CLOCK_DIVISOR_WIDTH-1:0] r_div;
  logic [2:0]                     r_bit_cnt;
  logic [2:0]                     r_last_bit;
  logic [7:0]                     r_shift;
  logic                           r_has_par;
  logic                           r_par_bit;
  logic                           r_two_stop;
  logic                           r_brk_min;
  logic                           r_tx;

  logic w_bit_end;
  logic w_accept;
  logic w_brk_start;

  // Parity over the counted data bits only; bits above the character width are masked.
  function automatic logic f_parity(input logic [7:0] data, input logic [1:0] bits,
                                    input logic [1:0] mode);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, bits});
    case (mode)
      2'b00:   f_parity = 1'b0;
      2'b11:   f_parity = 1'b1;
      2'b01:   f_parity = ^(data & mask);
      default: f_parity = ~^(data & mask);
    endcase
  endfunction

  assign w_bit_end   = (r_div_cnt == r_div);
  assign ready       = (r_state == S_IDLE) && !sendBreak && !rst;
  assign w_accept    = ready && sendData;
  assign w_brk_start = (r_state == S_IDLE) && sendBreak && !rst;
  assign busy        = (r_state != S_IDLE);
  assign tx          = r_tx;
  assign dataSent    = !rst && (r_state == S_STOP) && w_bit_end && (!r_two_stop || r_bit_cnt[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_brk_min <= 1'b0;
    end else begin
      r_div_cnt <= w_bit_end ? '0 : r_div_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_brk_min <= 1'b0;
          if (sendBreak) begin
            r_state <= S_BREAK;
            r_tx    <= 1'b0;
          end else if (sendData) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == r_last_bit) begin
              r_bit_cnt <= '0;
              r_state   <= r_has_par ? S_PARITY : S_STOP;
              r_tx      <= r_has_par ? r_par_bit : 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_two_stop && !r_bit_cnt[0]) begin
              r_bit_cnt <= 3'd1;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (w_bit_end) r_brk_min <= 1'b1;
          // Release as soon as the line is free and at least one full bit period has elapsed.
          if (!sendBreak && (r_brk_min || w_bit_end)) begin
            r_state   <= S_MARK;
            r_tx      <= 1'b1;
            r_div_cnt <= '0;
          end
        end
        S_MARK: begin
          if (w_bit_end) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Character and line configuration are frozen at acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift    <= dataIn;
      r_last_bit <= {1'b0, dataBits} + 3'd4;
      r_has_par  <= hasParity;
      r_par_bit  <= f_parity(dataIn, dataBits, parityMode);
      r_two_stop <= extraStopBit;
      r_div      <= clockDivisor;
    end else if (w_brk_start) begin
      r_div <= clockDivisor;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a frame-level line model compared every cycle, plus
// directed frames whose waveforms are pinned by hand-computed literals.
module tb_uart_transmitter;
  localparam int CDW = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     dataBits;
  logic           hasParity;
  logic [1:0]     parityMode;
  logic           extraStopBit;
  logic [CDW-1:0] clockDivisor;
  logic [7:0]     dataIn;
  logic           sendData;
  logic           ready;
  logic           sendBreak;
  logic           tx;
  logic           busy;
  logic           dataSent;

  uart_transmitter #(.CLOCK_DIVISOR_WIDTH(CDW)) dut (
    .clk(clk), .rst(rst), .dataBits(dataBits), .hasParity(hasParity),
    .parityMode(parityMode), .extraStopBit(extraStopBit), .clockDivisor(clockDivisor),
    .dataIn(dataIn), .sendData(sendData), .ready(ready), .sendBreak(sendBreak),
    .tx(tx), .busy(busy), .dataSent(dataSent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, {63'd0, got}, {63'd0, exp});
  endtask

  // Line model: queue of {tx, dataSent} for every future busy cycle of a frame or mark.
  logic [1:0] m_q[$];
  bit         m_brk = 0;
  int         m_cnt = 0;
  int         m_bdiv = 0;
  bit         m_idle_prev;

  function automatic void push_frame(input logic [7:0] d, input logic [1:0] db, input logic hp,
                                     input logic [1:0] pm, input logic es, input int div);
    logic fb[$];
    int   n;
    int   ones;
    int   last;
    n = int'(db) + 5;
    ones = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      fb.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (hp) begin
      case (pm)
        2'b00:   fb.push_back(1'b0);
        2'b11:   fb.push_back(1'b1);
        2'b01:   fb.push_back((ones % 2) == 1);
        default: fb.push_back((ones % 2) == 0);
      endcase
    end
    fb.push_back(1'b1);
    if (es) fb.push_back(1'b1);
    last = fb.size() - 1;
    for (int j = 0; j <= last; j++)
      for (int r = 0; r <= div; r++)
        m_q.push_back({fb[j], (j == last && r == div) ? 1'b1 : 1'b0});
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_brk = 0;
    end else begin
      m_idle_prev = (m_q.size() == 0) && !m_brk;
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_brk) begin
        m_cnt++;
        if (!sendBreak && m_cnt >= m_bdiv + 1) begin
          m_brk = 0;
          for (int r = 0; r <= m_bdiv; r++) m_q.push_back(2'b10);
        end
      end else if (m_idle_prev) begin
        if (sendBreak) begin
          m_brk  = 1;
          m_cnt  = 0;
          m_bdiv = int'(clockDivisor);
        end else if (sendData) begin
          push_frame(dataIn, dataBits, hasParity, parityMode, extraStopBit, int'(clockDivisor));
        end
      end
    end
  end

  initial forever begin
    logic e_tx, e_busy, e_ds, e_rdy;
    @(negedge clk);
    if (chk_en) begin
      e_busy = m_brk || (m_q.size() > 0);
      e_tx   = m_brk ? 1'b0 : (m_q.size() > 0 ? m_q[0][1] : 1'b1);
      e_ds   = !rst && !m_brk && (m_q.size() > 0) && m_q[0][0];
      e_rdy  = !rst && !e_busy && !sendBreak;
      check1("tx", tx, e_tx);
      check1("busy", busy, e_busy);
      check1("dataSent", dataSent, e_ds);
      check1("ready", ready, e_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic hp, input logic [1:0] pm,
                         input logic es, input int div, input logic [7:0] d);
    dataBits = db; hasParity = hp; parityMode = pm; extraStopBit = es;
    clockDivisor = CDW'(div); dataIn = d;
  endtask

  task automatic wait_accept(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ready === 1'b1 && sendData) ok = 1;
      tick();
    end
    if (!ok) check1({name, "_accept_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic directed(input string name, input logic [1:0] db, input logic hp,
                          input logic [1:0] pm, input logic es, input int div,
                          input logic [7:0] d, input int nbits, input logic [15:0] lit);
    bit ok;
    int len;
    logic [63:0] g_tx, e_tx, g_ds, e_ds;
    logic last_rdy, last_tx;
    set_cfg(db, hp, pm, es, div, d);
    sendData = 1'b1;
    wait_accept(name, ok);
    sendData = 1'b0;
    if (!ok) return;
    set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 7), 8'($urandom_range(0, 255)));
    len = nbits * (div + 1);
    check({name, "_model_len"}, 64'(m_q.size()), 64'(len));
    g_tx = '0; g_ds = '0; e_tx = '0; e_ds = '0;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      g_tx[k] = tx;
      g_ds[k] = dataSent;
      last_rdy = ready;
      last_tx = tx;
    end
    for (int k = 1; k <= len; k++) e_tx[k] = lit[(k - 1) / (div + 1)];
    e_tx[len + 1] = 1'b1;
    e_ds[len] = 1'b1;
    check({name, "_tx"}, g_tx, e_tx);
    check({name, "_dataSent"}, g_ds, e_ds);
    check1({name, "_ready_after"}, last_rdy, 1'b1);
    check1({name, "_idle_tx"}, last_tx, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int accepts;
    int brk_hold;
    bit acc_now;
    logic [63:0] g_tx, g_busy, g_ds, g_rdy, e_v, msk;

    rst = 1'b1; sendData = 1'b0; sendBreak = 1'b0;
    set_cfg(2'd3, 1'b0, 2'd0, 1'b0, 0, 8'h00);
    tick(); tick();
    chk_en = 1;
    @(negedge clk);
    check1("rst_tx", tx, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_dataSent", dataSent, 1'b0);
    check1("rst_ready", ready, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", ready, 1'b1);
    tick();

    directed("8N1_55", 2'd3, 1'b0, 2'b00, 1'b0, 3, 8'h55, 10, 16'h02AA);
    directed("7E1_C1", 2'd2, 1'b1, 2'b01, 1'b0, 0, 8'hC1, 10, 16'h0282);
    directed("5O2_1F", 2'd0, 1'b1, 2'b10, 1'b1, 1, 8'h1F, 9, 16'h01BE);

    // Back-to-back frames with sendData held.
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 0, 8'h11);
    sendData = 1'b1;
    wait_accept("b2b", ok);
    dataIn = 8'h22;
    accepts = 1;
    g_tx = '0; g_busy = '0; g_ds = '0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      g_tx[k] = tx; g_busy[k] = busy; g_ds[k] = dataSent;
      acc_now = (ready === 1'b1) && sendData;
      tick();
      if (acc_now) begin
        accepts++;
        dataIn = (accepts == 2) ? 8'h33 : 8'h44;
        if (accepts == 3) sendData = 1'b0;
      end
    end
    sendData = 1'b0;
    check("b2b_accepts", 64'(accepts), 64'd3);
    e_v = '0; e_v[10] = 1'b1; e_v[21] = 1'b1; e_v[32] = 1'b1;
    check("b2b_dataSent", g_ds, e_v);
    e_v = '0;
    for (int k = 1; k <= 33; k++) e_v[k] = !(k == 11 || k == 22 || k == 33);
    check("b2b_busy", g_busy, e_v);
    check1("b2b_gap1_tx", g_tx[11], 1'b1);
    check1("b2b_gap2_tx", g_tx[22], 1'b1);
    tick();

    // Break raised mid-frame.
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 3, 8'hA5);
    sendData = 1'b1;
    wait_accept("brk", ok);
    sendData = 1'b0;
    g_tx = '0; g_rdy = '0; g_ds = '0;
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      g_tx[k] = tx; g_rdy[k] = ready; g_ds[k] = dataSent;
      tick();
      if (k == 10) sendBreak = 1'b1;
      if (k == 50) sendBreak = 1'b0;
    end
    e_v = '0; e_v[40] = 1'b1;
    check("brk_dataSent", g_ds, e_v);
    msk = '0; e_v = '0;
    for (int k = 41; k <= 56; k++) begin
      msk[k] = 1'b1;
      e_v[k] = !(k >= 42 && k <= 51);
    end
    check("brk_tx", g_tx & msk, e_v);
    e_v = '0; e_v[56] = 1'b1;
    check("brk_ready", g_rdy & msk, e_v);
    tick();

    // Reset during data bit 3, then a clean frame.
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0, 1, 8'h00);
    sendData = 1'b1;
    wait_accept("rstmid", ok);
    sendData = 1'b0;
    g_tx = '0; g_busy = '0; g_ds = '0; g_rdy = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      g_tx[k] = tx; g_busy[k] = busy; g_ds[k] = dataSent; g_rdy[k] = ready;
      tick();
      if (k == 8) rst = 1'b1;
      if (k == 9) rst = 1'b0;
    end
    check1("rstmid_tx_before", g_tx[9], 1'b0);
    check1("rstmid_tx_after", g_tx[10], 1'b1);
    check1("rstmid_busy_after", g_busy[10], 1'b0);
    check1("rstmid_ready_after", g_rdy[10], 1'b1);
    check("rstmid_dataSent", g_ds, 64'd0);
    directed("after_rst_3C", 2'd3, 1'b0, 2'b00, 1'b0, 0, 8'h3C, 10, 16'h0278);

    // Randomized traffic: config churn every cycle, breaks and occasional resets.
    brk_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom_range(0, 255)));
      sendData = ($urandom_range(0, 2) != 0);
      if (brk_hold > 0) begin
        brk_hold--;
        sendBreak = 1'b1;
      end else begin
        sendBreak = 1'b0;
        if ($urandom_range(0, 99) == 0) brk_hold = $urandom_range(1, 12);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; sendData = 1'b0; sendBreak = 1'b0;
    repeat (80) tick();
    check1("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
